// File: rtl/p_mac_accumulator_pkg.sv
// Shared types and arithmetic for the MAC accumulator downstream of the pipelined multiplier.
package p_mac_accumulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } mac_state_e;

  // Widest accumulator the saturating adder supports.
  localparam int SAT_W = 64;

  // Saturating add at acc_width bits. Bits [acc_width-1:0] hold the sum, clamped to all-ones
  // on overflow, and bit acc_width holds the overflow flag, so callers keep the low acc_width+1 bits.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int unsigned      acc_width);
    logic [SAT_W:0] one;
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    one = {{SAT_W{1'b0}}, 1'b1};
    s   = {1'b0, a} + {1'b0, b};
    lim = (one << acc_width) - one;
    if (s > lim) sat_add = (one << acc_width) | lim;
    else         sat_add = s;
  endfunction

endpackage

// File: rtl/p_mac_accumulator_if.sv
// Product-stream input and vector-result output of the MAC accumulator.
interface p_mac_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + 8,
  parameter int CNT_WIDTH = 16
);
  // in_valid/in_last qualify the operand pair entering the multiplier this cycle; in_last is
  // meaningful only with in_valid. out_valid pulses for one cycle per vector, with no ready.
  logic                   in_valid;
  logic                   in_last;
  logic [2*WIDTH-1:0]     prod;
  logic [ACC_WIDTH-1:0]   acc_out;
  logic                   out_valid;
  logic [CNT_WIDTH-1:0]   out_count;
  logic                   out_ovf;

  modport master (
    output in_valid, in_last, prod,
    input  acc_out, out_valid, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_last, prod,
    output acc_out, out_valid, out_count, out_ovf
  );

endinterface

// File: rtl/p_mac_accumulator_tag_delay.sv
// Shift register carrying operand tags alongside the multiplier pipeline, with synchronous clear.
module p_mac_accumulator_tag_delay #(
  parameter int DEPTH = 5,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/p_mac_accumulator.sv
// Sums tagged multiplier products into per-vector saturating dot products, one result per vector.
module p_mac_accumulator
  import p_mac_accumulator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MULT_DELAY = 5,
  parameter int ACC_WIDTH  = 2 * WIDTH + 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  p_mac_accumulator_if.slave   mac_io,
  output mac_state_e           state_o
);

  logic [1:0]           tag_d;
  logic                 d_valid;
  logic                 d_last;

  mac_state_e           state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic [ACC_WIDTH-1:0] acc_out_q;
  logic                 out_valid_q;
  logic [CNT_WIDTH-1:0] out_count_q;
  logic                 out_ovf_q;

  logic [ACC_WIDTH-1:0] base_acc;
  logic [CNT_WIDTH-1:0] base_cnt;
  logic                 base_ovf;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_d;
  logic                 add_ovf;

  p_mac_accumulator_tag_delay #(
    .DEPTH (MULT_DELAY),
    .W     (2)
  ) u_tag_delay (
    .clk     (clk),
    .clear_i (reset),
    .d_i     ({mac_io.in_valid, mac_io.in_last}),
    .q_o     (tag_d)
  );

  assign d_valid = tag_d[1];
  assign d_last  = tag_d[0];

  // A vector always starts from zero in IDLE, so a new vector never inherits the old sum.
  always_comb begin
    base_acc = '0;
    base_cnt = '0;
    base_ovf = 1'b0;
    if (state_q == ACC) begin
      base_acc = acc_q;
      base_cnt = cnt_q;
      base_ovf = ovf_q;
    end
    {add_ovf, acc_d} = (ACC_WIDTH + 1)'(sat_add(SAT_W'(base_acc), SAT_W'(mac_io.prod), ACC_WIDTH));
    ovf_d = base_ovf | add_ovf;
    cnt_d = (&base_cnt) ? base_cnt : base_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (d_valid) begin
        if (d_last) begin
          acc_out_q   <= acc_d;
          out_count_q <= cnt_d;
          out_ovf_q   <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end else begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          state_q <= ACC;
        end
      end
    end
  end

  assign mac_io.acc_out   = acc_out_q;
  assign mac_io.out_valid = out_valid_q;
  assign mac_io.out_count = out_count_q;
  assign mac_io.out_ovf   = out_ovf_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_p_mac_accumulator.sv
// Directed bench: a behavioural 5-stage multiplier feeds a 24-bit and a 17-bit accumulator in parallel.
module tb_p_mac_accumulator;
  import p_mac_accumulator_pkg::*;

  localparam int WIDTH      = 8;
  localparam int MULT_DELAY = 5;
  localparam int CNT_WIDTH  = 16;
  localparam int EXP_W      = 32 + 1 + CNT_WIDTH + 24;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0]   a_in = '0;
  logic [WIDTH-1:0]   b_in = '0;
  logic               v_in = 1'b0;
  logic               l_in = 1'b0;

  // Multiplier model; its stages are deliberately not cleared by reset.
  logic [2*WIDTH-1:0] prod_pipe [MULT_DELAY];
  always @(posedge clk) begin
    prod_pipe[0] <= 16'(a_in) * 16'(b_in);
    for (int i = 1; i < MULT_DELAY; i++) prod_pipe[i] <= prod_pipe[i-1];
  end

  p_mac_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(24), .CNT_WIDTH(CNT_WIDTH)) if24 ();
  p_mac_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(17), .CNT_WIDTH(CNT_WIDTH)) if17 ();

  assign if24.in_valid = v_in;
  assign if24.in_last  = l_in;
  assign if24.prod     = prod_pipe[MULT_DELAY-1];
  assign if17.in_valid = v_in;
  assign if17.in_last  = l_in;
  assign if17.prod     = prod_pipe[MULT_DELAY-1];

  mac_state_e state24;
  mac_state_e state17;

  p_mac_accumulator #(.WIDTH(WIDTH), .MULT_DELAY(MULT_DELAY), .ACC_WIDTH(24), .CNT_WIDTH(CNT_WIDTH)) dut24 (
    .clk     (clk),
    .reset   (reset),
    .mac_io  (if24),
    .state_o (state24)
  );

  p_mac_accumulator #(.WIDTH(WIDTH), .MULT_DELAY(MULT_DELAY), .ACC_WIDTH(17), .CNT_WIDTH(CNT_WIDTH)) dut17 (
    .clk     (clk),
    .reset   (reset),
    .mac_io  (if17),
    .state_o (state17)
  );

  // scoreboard
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [EXP_W-1:0] exp24_q [$];
  logic [EXP_W-1:0] exp17_q [$];
  logic [EXP_W-1:0] e24;
  logic [EXP_W-1:0] e17;

  // Call in the cycle the last operand is presented; result is due MULT_DELAY+1 cycles later.
  task automatic expect_out(input logic [23:0] acc24, input logic [23:0] acc17,
                            input logic [CNT_WIDTH-1:0] cnt, input logic ovf24, input logic ovf17);
    exp24_q.push_back({32'(cyc + MULT_DELAY + 1), ovf24, cnt, acc24});
    exp17_q.push_back({32'(cyc + MULT_DELAY + 1), ovf17, cnt, acc17});
  endtask

  always @(negedge clk) begin
    if (if24.out_valid) begin
      if (exp24_q.size() == 0) check_val("spurious out_valid acc24", if24.out_valid, 1'b0);
      else begin
        e24 = exp24_q.pop_front();
        check_val("acc24 cycle", cyc, e24[72:41]);
        check_val("acc24 acc_out", if24.acc_out, e24[23:0]);
        check_val("acc24 out_count", if24.out_count, e24[39:24]);
        check_val("acc24 out_ovf", if24.out_ovf, e24[40]);
      end
    end
    if (if17.out_valid) begin
      if (exp17_q.size() == 0) check_val("spurious out_valid acc17", if17.out_valid, 1'b0);
      else begin
        e17 = exp17_q.pop_front();
        check_val("acc17 cycle", cyc, e17[72:41]);
        check_val("acc17 acc_out", if17.acc_out, e17[23:0]);
        check_val("acc17 out_count", if17.out_count, e17[39:24]);
        check_val("acc17 out_ovf", if17.out_ovf, e17[40]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l);
    a_in = a;
    b_in = b;
    v_in = v;
    l_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset acc_out", if24.acc_out, 0);
    check_val("reset out_valid", if24.out_valid, 0);
    check_val("reset out_count", if24.out_count, 0);
    check_val("reset out_ovf", if24.out_ovf, 0);
    check_val("reset state", state24, IDLE);
    check_val("reset acc_out 17", if17.acc_out, 0);
    reset = 1'b0;

    // three-term vector: 12+30+56
    drive(8'd3, 8'd4, 1'b1, 1'b0);
    drive(8'd5, 8'd6, 1'b1, 1'b0);
    expect_out(24'd98, 24'd98, 16'd1 + 16'd2, 1'b0, 1'b0);
    drive(8'd7, 8'd8, 1'b1, 1'b1);
    idle(8);

    // back-to-back single-term vectors
    expect_out(24'd65025, 24'd65025, 16'd1, 1'b0, 1'b0);
    drive(8'd255, 8'd255, 1'b1, 1'b1);
    expect_out(24'd4, 24'd4, 16'd1, 1'b0, 1'b0);
    drive(8'd2, 8'd2, 1'b1, 1'b1);
    idle(8);
    check_val("acc_out holds", if24.acc_out, 4);

    // gaps inside a vector: 1+6+16
    drive(8'd1, 8'd1, 1'b1, 1'b0);
    idle(2);
    drive(8'd2, 8'd3, 1'b1, 1'b0);
    idle(1);
    expect_out(24'd23, 24'd23, 16'd3, 1'b0, 1'b0);
    drive(8'd4, 8'd4, 1'b1, 1'b1);
    idle(8);

    // saturation in the 17-bit instance only, then a clean vector
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    expect_out(24'd195075, 24'd131071, 16'd3, 1'b0, 1'b1);
    drive(8'd255, 8'd255, 1'b1, 1'b1);
    expect_out(24'd1, 24'd1, 16'd1, 1'b0, 1'b0);
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    idle(8);

    // reset while tags are still in flight
    drive(8'd9, 8'd9, 1'b1, 1'b0);
    drive(8'd9, 8'd9, 1'b1, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_val("in-flight reset acc_out", if24.acc_out, 0);
    expect_out(24'd10, 24'd10, 16'd1, 1'b0, 1'b0);
    drive(8'd2, 8'd5, 1'b1, 1'b1);
    idle(8);

    // reset while a partial sum is held
    drive(8'd9, 8'd9, 1'b1, 1'b0);
    idle(7);
    check_val("partial state ACC", state24, ACC);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_val("partial reset state", state24, IDLE);
    check_val("partial reset acc_out", if24.acc_out, 0);
    expect_out(24'd10, 24'd10, 16'd1, 1'b0, 1'b0);
    drive(8'd2, 8'd5, 1'b1, 1'b1);
    idle(8);

    // in_last without in_valid is ignored: 1+4
    drive(8'd1, 8'd1, 1'b1, 1'b0);
    drive(8'd7, 8'd7, 1'b0, 1'b1);
    expect_out(24'd5, 24'd5, 16'd2, 1'b0, 1'b0);
    drive(8'd2, 8'd2, 1'b1, 1'b1);
    idle(8);

    // reset on the completion cycle suppresses the result
    drive(8'd3, 8'd3, 1'b1, 1'b1);
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(8);
    check_val("reset-wins acc_out", if24.acc_out, 0);
    check_val("reset-wins out_count", if24.out_count, 0);

    // new vector right after a last starts fresh: 4, then 9+1
    expect_out(24'd4, 24'd4, 16'd1, 1'b0, 1'b0);
    drive(8'd2, 8'd2, 1'b1, 1'b1);
    drive(8'd3, 8'd3, 1'b1, 1'b0);
    expect_out(24'd10, 24'd10, 16'd2, 1'b0, 1'b0);
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    idle(10);

    check_val("acc24 results outstanding", exp24_q.size(), 0);
    check_val("acc17 results outstanding", exp17_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/p_mac_accumulator.md
# p_mac_accumulator

Accumulates the product stream of the team's pipelined unsigned multiplier into per-vector dot-product sums. Sits directly downstream of the multiplier. Carries the valid and last tags issued alongside the multiplier operands through a delay line matched to the multiplier latency, then sums each tagged vector. Emits one registered result per vector, with a term count and a saturation flag.

## Interface
- WIDTH, 8: multiplier operand width; products are 2*WIDTH bits, unsigned.
- MULT_DELAY, 5: cycles from operands presented at the multiplier input to the product at its output (operand register, product register, 3 pipeline stages).
- ACC_WIDTH, 2*WIDTH+8: accumulator and result width; must be at least 2*WIDTH.
- CNT_WIDTH, 16: term-counter width.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair valid this cycle, aligned with the multiplier's operand inputs.
- in_last  in  1  final operand pair of the current vector; ignored unless in_valid.
- prod  in  2*WIDTH  multiplier result.
- acc_out  out  ACC_WIDTH  completed vector sum; holds until the next completion.
- out_valid  out  1  one-cycle pulse when acc_out, out_count and out_ovf update.
- out_count  out  CNT_WIDTH  number of terms in the completed vector.
- out_ovf  out  1  the completed vector saturated.

## Operation
- Delay line: {in_valid, in_last} shifts through MULT_DELAY registers. Tap d_valid/d_last is aligned with prod.
  - Reset clears the delay line. Products the multiplier emits after reset are ignored, because the multiplier's internal stages are not cleared.
- States:
  - IDLE: no partial sum.
  - ACC: partial sum held in acc, count in cnt, sticky ovf.
- Transitions on d_valid:
  - IDLE, d_valid and !d_last: acc=prod, cnt=1, ovf=0, go to ACC.
  - IDLE, d_valid and d_last: complete a single-term vector with sum=prod, count 1; stay in IDLE.
  - ACC, d_valid and !d_last: acc=acc+prod, cnt+1; stay in ACC.
  - ACC, d_valid and d_last: complete with acc+prod; go to IDLE.
  - !d_valid: hold all state (gaps allowed anywhere in a vector).
- Arithmetic: unsigned, computed at ACC_WIDTH+1 bits.
  - If the sum exceeds 2^ACC_WIDTH-1, the result is all-ones and ovf is set; ovf stays set for the rest of the vector.
  - cnt saturates at all-ones.
- Completion registers acc_out, out_count and out_ovf, and pulses out_valid.
- A new vector may begin on the cycle immediately after a last; it starts from prod, never from the old sum.

## Timing
- Reset values: acc_out=0, out_valid=0, out_count=0, out_ovf=0, state IDLE, delay line 0.
- Latency: an in_last asserted at input cycle t gives out_valid at cycle t+MULT_DELAY+1.
- Throughput: one term per cycle. Back-to-back single-term vectors produce out_valid every cycle.
- Reset asserted mid-vector discards the partial sum and all in-flight tags. No out_valid occurs for that vector, and the first output after reset comes from operands issued after reset deasserts.
- Reset and completion in the same cycle: reset wins; out_valid=0.
- No backpressure: the consumer must accept every out_valid pulse.

## Structure
- The shared package holds the state enum (IDLE, ACC) and a sat_add helper constant/function: an ACC_WIDTH-bit saturating add that returns the sum and an overflow bit.
- One sub-module is natural: tag_delay, a parameterised shift register of depth MULT_DELAY and width 2, with synchronous clear.
- The top level instantiates tag_delay next to the accumulator state machine. The multiplier itself is instantiated by the parent, not inside this block.

## Test plan
All scenarios use WIDTH=8, MULT_DELAY=5, ACC_WIDTH=24 unless stated.
- Operands (3,4), (5,6), (7,8) with last on the third, issued at cycles 0-2: out_valid at cycle 8, acc_out=98, out_count=3, out_ovf=0.
- Single term (255,255) with last: acc_out=65025, out_count=1. A second single-term vector (2,2) on the next cycle: out_valid on two consecutive cycles, the second with acc_out=4.
- Vector (1,1) gap gap (2,3) gap (4,4)-last: acc_out=23, out_count=3; out_valid 6 cycles after the last is issued.
- ACC_WIDTH=17, three terms of (255,255): sum 195075 exceeds 131071, so acc_out=131071 and out_ovf=1. The next vector (1,1)-last gives acc_out=1, out_ovf=0.
- Issue (9,9), (9,9), then reset for 1 cycle, then (2,5)-last: no output for the first vector; acc_out=10, out_count=1.
- in_last asserted while in_valid=0: no effect; the vector continues and completes only on a valid last.
